seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an NDIG-digit 7-segment display.

---
 rtl/seg_scan_ctrl_pkg.sv | 13 +
 rtl/seg_scan_ctrl_bcd7seg.sv | 25 ++
 rtl/seg_scan_ctrl.sv | 93 +++++++++
 tb/tb_seg_scan_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: scan FSM encoding, blank segment pattern and counter sizing
package seg_scan_ctrl_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic int cnt_width(input int div, input int dead);
    int m;
    m = (div > dead) ? div : dead;
    m = (m > 2) ? m : 2;
    return $clog2(m);
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_bcd7seg.sv
// bcd7seg: hex nibble to active-low {a..g} segment pattern
module bcd7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan with dead time and frame-synchronous load/ack
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int DIV  = 1000,
  parameter int DEAD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   blank,
  output logic              ack,
  output logic              frame_tick,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg
);
  localparam int CW = cnt_width(DIV, DEAD);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'((DEAD > 0) ? DEAD - 1 : 0);
  localparam logic [IW-1:0] LAST     = IW'(NDIG - 1);
  logic [1:0]        state, state_n;
  logic [IW-1:0]     idx, idx_n, idx_inc;
  logic [CW-1:0]     cnt, cnt_n;
  logic [4*NDIG-1:0] shadow, active, active_n;
  logic [NDIG-1:0]   sblank, blank_act, blank_n;
  logic              pending, go;
  logic [3:0]        nib;
  logic [6:0]        dec;
  assign idx_inc    = (idx == LAST) ? '0 : idx + 1'b1;
  assign frame_tick = (idx == LAST) & ((state == S_DEAD & cnt == DEAD_END) |
                      ((DEAD == 0) & state == S_DRIVE & cnt == DIV_END));
  // a load landing on frame_tick bypasses the shadow so one ack covers it
  assign go        = (frame_tick | state == S_IDLE) & (pending | (load & frame_tick));
  assign active_n  = go ? (load ? data : shadow) : active;
  assign blank_n   = go ? (load ? blank : sblank) : blank_act;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 1'b1;
    if (!en) begin
      state_n = S_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else if (state != S_DRIVE && state != S_DEAD) begin
      state_n = S_DRIVE;
      idx_n   = '0;
      cnt_n   = '0;
    end else if (state == S_DRIVE && cnt == DIV_END) begin
      state_n = (DEAD > 0) ? S_DEAD : S_DRIVE;
      idx_n   = (DEAD > 0) ? idx : idx_inc;
      cnt_n   = '0;
    end else if (state == S_DEAD && cnt == DEAD_END) begin
      state_n = S_DRIVE;
      idx_n   = idx_inc;
      cnt_n   = '0;
    end
  end
  // decode the digit about to be driven so seg lines up with an
  assign nib = active_n[{idx_n, 2'b00} +: 4];
  bcd7seg u_dec (.hex(nib), .seg(dec));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      an        <= '1;
      seg       <= SEG_BLANK;
      ack       <= 1'b0;
      shadow    <= '0;
      sblank    <= '0;
      active    <= '0;
      blank_act <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      an        <= (state_n == S_DRIVE && !blank_n[idx_n]) ? ~(NDIG'(1) << idx_n) : '1;
      seg       <= (state_n == S_DRIVE) ? dec : SEG_BLANK;
      ack       <= go;
      active    <= active_n;
      blank_act <= blank_n;
      pending   <= (pending | load) & !go;
      if (load) begin
        shadow <= data;
        sblank <= blank;
      end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: DEAD=1 and DEAD=0 builds against a time-position reference model
module tb_seg_scan_ctrl;
  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam logic [6:0] FONT [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                       7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic clk = 0, rst = 1, en = 0, load = 0;
  logic [15:0] data = 0;
  logic [3:0] blank = 0;
  logic ack_a, ft_a, ack_b, ft_b;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .DEAD(1)) dut_a (.clk(clk), .rst(rst), .en(en), .load(load),
    .data(data), .blank(blank), .ack(ack_a), .frame_tick(ft_a), .an(an_a), .seg(seg_a));
  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .DEAD(0)) dut_b (.clk(clk), .rst(rst), .en(en), .load(load),
    .data(data), .blank(blank), .ack(ack_b), .frame_tick(ft_b), .an(an_b), .seg(seg_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: k=0 is DEAD=1, k=1 is DEAD=0; position t counts cycles since scan start
  int m_t [2];
  bit m_on [2], m_pend [2], m_ack [2];
  logic [15:0] m_act [2], m_sh [2];
  logic [3:0] m_ba [2], m_sb [2];
  function automatic int per(input int k);
    return DIV + ((k == 0) ? 1 : 0);
  endfunction
  function automatic bit m_ft(input int k);
    return m_on[k] && (m_t[k] % (NDIG * per(k)) == NDIG * per(k) - 1);
  endfunction
  function automatic bit m_drive(input int k);
    return m_on[k] && (m_t[k] % per(k) < DIV);
  endfunction
  function automatic int m_dig(input int k);
    return (m_t[k] / per(k)) % NDIG;
  endfunction
  function automatic logic [3:0] exp_an(input int k);
    int d;
    d = m_dig(k);
    return (m_drive(k) && !m_ba[k][d]) ? ~(4'b0001 << d) : 4'hF;
  endfunction
  function automatic logic [6:0] exp_seg(input int k);
    int d;
    d = m_dig(k);
    return m_drive(k) ? FONT[m_act[k][4*d +: 4]] : 7'h7F;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_t[k] = 0; m_on[k] = 0; m_pend[k] = 0; m_ack[k] = 0;
        m_act[k] = 0; m_sh[k] = 0; m_ba[k] = 0; m_sb[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit ft, go;
        ft = m_ft(k);
        go = (ft || !m_on[k]) && (m_pend[k] || (load && ft));
        if (go) begin
          m_act[k] = load ? data : m_sh[k];
          m_ba[k]  = load ? blank : m_sb[k];
        end
        m_pend[k] = !go && (m_pend[k] || load);
        m_ack[k] = go;
        if (load) begin
          m_sh[k] = data;
          m_sb[k] = blank;
        end
        if (!en) begin
          m_on[k] = 0; m_t[k] = 0;
        end else if (!m_on[k]) begin
          m_on[k] = 1; m_t[k] = 0;
        end else m_t[k] = (m_t[k] + 1) % (NDIG * per(k));
      end
    end
  end
  always @(negedge clk)
    if (!rst) begin
      chk("an_a", an_a, exp_an(0));
      chk("seg_a", seg_a, exp_seg(0));
      chk("ack_a", ack_a, m_ack[0]);
      chk("ft_a", ft_a, m_ft(0));
      chk("an_b", an_b, exp_an(1));
      chk("seg_b", seg_b, exp_seg(1));
      chk("ack_b", ack_b, m_ack[1]);
      chk("ft_b", ft_b, m_ft(1));
    end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ft(input bit sel);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++)
      if (sel ? ft_b : ft_a) ok = 1;
      else step(1);
    if (!ok) chk("ft_timeout", 0, 1);
  endtask
  initial begin
    int n, gaps, acks, drv0, low2;
    logic [6:0] s;
    step(2);
    rst = 0;
    step(50);
    chk("rst_an", an_a, 4'b1111);
    chk("rst_seg", seg_a, 7'h7F);
    chk("rst_ack", ack_a, 0);
    data = 16'h3210; load = 1;
    step(1);
    load = 0; en = 1;
    step(1);
    chk("ack_start", ack_a, 1);
    chk("d0_an", an_a, 4'b1110);
    chk("d0_seg", seg_a, 7'b0000001);
    step(10);
    chk("d2_an", an_a, 4'b1011);
    chk("d2_seg", seg_a, 7'b0010010);
    wait_ft(0);
    step(1);
    n = 1;
    while (!ft_a && n < 50) begin step(1); n++; end
    chk("frame_a", n, 20);
    wait_ft(1);
    step(1);
    n = 1; gaps = 0;
    while (!ft_b && n < 50) begin gaps += (an_b == 4'hF); step(1); n++; end
    gaps += (an_b == 4'hF);
    chk("frame_b", n, 16);
    chk("gaps_b", gaps, 0);
    wait_ft(0);
    step(8);
    data = 16'hFEDC; load = 1;
    step(1);
    load = 0;
    n = 1;
    while (!ack_a && n < 40) begin step(1); n++; end
    chk("ack_lat", n, 13);
    chk("c_seg", seg_a, 7'b0110001);
    wait_ft(0);
    step(20);
    chk("ft_again", ft_a, 1);
    data = 16'h5A5A; load = 1;
    step(1);
    load = 0;
    chk("ack_bypass", ack_a, 1);
    chk("a_seg", seg_a, 7'b0001000);
    acks = ack_a;
    repeat (25) begin step(1); acks += ack_a; end
    chk("single_ack", acks, 1);
    wait_ft(0);
    step(4);
    data = 16'hAAAA; load = 1;
    step(1);
    data = 16'hB0B1;
    step(1);
    load = 0;
    acks = 0; s = 0;
    repeat (25) begin
      if (ack_a) s = seg_a;
      acks += ack_a;
      step(1);
    end
    chk("dbl_ack", acks, 1);
    chk("dbl_seg", s, 7'b1001111);
    blank = 4'b0100; data = 16'h7654; load = 1;
    step(1);
    load = 0; blank = 0;
    wait_ft(0);
    step(1);
    drv0 = 0; low2 = 0;
    repeat (20) begin
      drv0 += (an_a == 4'b1110);
      low2 += (an_a[2] == 1'b0);
      step(1);
    end
    chk("drive_len", drv0, 4);
    chk("blank2", low2, 0);
    step(9);
    en = 0;
    step(1);
    chk("en_off_an", an_a, 4'hF);
    chk("en_off_seg", seg_a, 7'h7F);
    step(5);
    en = 1;
    step(1);
    chk("restart_a", an_a, 4'b1110);
    chk("restart_b", an_b, 4'b1110);
    step(1);
    #2 rst = 1;
    #1;
    chk("arst_an_a", an_a, 4'hF);
    chk("arst_an_b", an_b, 4'hF);
    chk("arst_seg_a", seg_a, 7'h7F);
    @(posedge clk);
    #1 rst = 0;
    step(1);
    chk("post_rst_an", an_a, 4'b1110);
    chk("post_rst_seg", seg_a, 7'b0000001);
    repeat (600) begin
      load = ($urandom_range(0, 7) == 0);
      data = 16'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 39) == 0) en = ~en;
      step(1);
    end
    load = 0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
